reg_bank_writer: RTL and testbench

//  Write-side counterpart of the constant-readout register modules: owns a small register bank,

---
 rtl/reg_bank_writer.sv | 176 +++++++++++++++++
 tb/tb_reg_bank_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_writer.sv
// ----------------------------------------------------------------------------
// reg_bank_writer
//   A small register bank that readers pull values from through a
//   combinational read port. It fills itself with constants and then takes
//   writes:
//     - After reset it steps through the entries, one per cycle, and loads
//       INIT_VALUE into each. This is the init sweep.
//     - After the sweep it accepts valid/ready write requests.
//     - A reinit pulse in RUN starts the sweep again.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   reinit     in   restart the init sweep (only honoured in RUN)
//   wr_valid   in   write request valid
//   wr_ready   out  write request ready (RUN and no concurrent reinit)
//   wr_addr    in   write entry index
//   wr_data    in   write data
//   rd_addr    in   read entry index
//   rd_data    out  bank[rd_addr]; zero when rd_addr is past the last entry
//   init_done  out  high once the sweep has finished
//   wr_err     out  sticky flag: an accepted write hit a non-existent entry
// ----------------------------------------------------------------------------

// One bank entry: a load-enabled register that resets to zero.
module reg_bank_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (we) data_d = wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= data_d;
    end

    assign q = data_q;
endmodule

module reg_bank_writer #(
    parameter int          WIDTH      = 8,
    parameter int          DEPTH      = 4,
    parameter int unsigned INIT_VALUE = 7,
    localparam int         ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              reinit,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              init_done,
    output logic              wr_err
);
    localparam logic [WIDTH-1:0]  INIT_W   = WIDTH'(INIT_VALUE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_req_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              init_done_q, init_done_d;
    logic              wr_err_q, wr_err_d;

    wr_req_t                       req;
    logic                          wr_fire;
    logic [DEPTH-1:0]              addr_hit;
    logic [DEPTH-1:0]              ent_we;
    logic [WIDTH-1:0]              ent_wdata;
    logic [DEPTH-1:0][WIDTH-1:0]   ent_q;

    assign req      = '{addr: wr_addr, data: wr_data};
    // reinit takes priority over a write in the same cycle, so ready drops
    // combinationally and the handshake cannot complete.
    assign wr_ready = (state_q == ST_RUN) && !reinit;
    assign wr_fire  = wr_valid && wr_ready;

    // One-hot decode of the write address. No bit is set for an
    // out-of-range address, so no entry can be touched by it.
    always_comb begin
        addr_hit = '0;
        for (int i = 0; i < DEPTH; i++)
            if (req.addr == ADDR_W'(i)) addr_hit[i] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        wr_err_d    = wr_err_q;
        ent_we      = '0;
        ent_wdata   = INIT_W;
        case (state_q)
            ST_INIT: begin
                for (int i = 0; i < DEPTH; i++)
                    if (idx_q == ADDR_W'(i)) ent_we[i] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (reinit) begin
                    // Entries keep their values until the sweep overwrites them.
                    state_d     = ST_INIT;
                    idx_d       = '0;
                    init_done_d = 1'b0;
                end else if (wr_fire) begin
                    ent_wdata = req.data;
                    ent_we    = addr_hit;
                    if (addr_hit == '0) wr_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            wr_err_q    <= wr_err_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        reg_bank_entry #(.WIDTH(WIDTH)) u_ent (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (ent_we[g]),
            .wdata   (ent_wdata),
            .q       (ent_q[g])
        );
    end

    // The read mux has no write bypass. A read of the entry being written
    // returns the old value until the next cycle.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rd_addr == ADDR_W'(i)) rd_data = ent_q[i];
    end

    assign init_done = init_done_q;
    assign wr_err    = wr_err_q;
endmodule

// File: tb/tb_reg_bank_writer.sv
// Two builds (DEPTH=4 and DEPTH=3) share one stimulus stream and are compared
// to a per-instance array model of the bank.
module tb_reg_bank_writer;
    localparam int IV = 7;
    localparam int DEP [2] = '{4, 3};

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       reinit   = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_addr  = '0;
    logic [7:0] wr_data  = '0;
    logic [1:0] rd_addr  = '0;

    logic       wr_ready_o  [2];
    logic [7:0] rd_data_o   [2];
    logic       init_done_o [2];
    logic       wr_err_o    [2];

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int mem  [2][4];
    int pos  [2];
    bit run  [2];
    bit done [2];
    bit err  [2];

    always #10 clock = ~clock;

    reg_bank_writer #(.WIDTH(8), .DEPTH(4), .INIT_VALUE(IV)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .reinit(reinit),
        .wr_valid(wr_valid), .wr_ready(wr_ready_o[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
        .init_done(init_done_o[0]), .wr_err(wr_err_o[0])
    );

    reg_bank_writer #(.WIDTH(8), .DEPTH(3), .INIT_VALUE(IV)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .reinit(reinit),
        .wr_valid(wr_valid), .wr_ready(wr_ready_o[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
        .init_done(init_done_o[1]), .wr_err(wr_err_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 4; a++) mem[k][a] = 0;
            pos[k] = 0; run[k] = 0; done[k] = 0; err[k] = 0;
        end
    endtask

    // Effect of one rising edge on the model, from the current inputs.
    task automatic model_edge();
        if (!reset_n) return;
        for (int k = 0; k < 2; k++) begin
            if (!run[k]) begin
                mem[k][pos[k]] = IV;
                if (pos[k] == DEP[k] - 1) begin
                    pos[k] = 0; run[k] = 1; done[k] = 1;
                end else pos[k]++;
            end else if (reinit) begin
                run[k] = 0; done[k] = 0; pos[k] = 0;
            end else if (wr_valid) begin
                if (int'(wr_addr) < DEP[k]) mem[k][wr_addr] = int'(wr_data);
                else err[k] = 1;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 2; k++) begin
            int exp_rd;
            exp_rd = (int'(rd_addr) < DEP[k]) ? mem[k][rd_addr] : 0;
            chk($sformatf("%s_d%0d_rdy", tag, DEP[k]), 32'(wr_ready_o[k]), 32'(run[k] && !reinit));
            chk($sformatf("%s_d%0d_done", tag, DEP[k]), 32'(init_done_o[k]), 32'(done[k]));
            chk($sformatf("%s_d%0d_err", tag, DEP[k]), 32'(wr_err_o[k]), 32'(err[k]));
            chk($sformatf("%s_d%0d_rd%0d", tag, DEP[k], rd_addr), 32'(rd_data_o[k]), exp_rd);
        end
    endtask

    // Called at a falling edge with inputs already set: check, then clock.
    task automatic step(input string tag);
        if (!reset_n) model_reset();
        #1;
        check_outs(tag);
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            check_outs(tag);
        end
    endtask

    task automatic idle();
        reinit = 0; wr_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clock);
        // reset state
        reset_n = 0;
        wr_valid = 1;
        step("rst");
        chk("rst_done", 32'(init_done_o[0]), 0);
        chk("rst_rdy", 32'(wr_ready_o[0]), 0);

        // 1: sweep takes 4 cycles, wr_valid held high is ignored
        reset_n = 1; wr_addr = 1; wr_data = 8'h55;
        for (int c = 0; c < 4; c++) step("t1");
        idle();
        #1;
        chk("t1_done", 32'(init_done_o[0]), 1);
        chk("t1_rdy", 32'(wr_ready_o[0]), 1);
        read_all("t1_rd");

        // 2: write addr2, same-cycle read shows old value
        @(negedge clock);
        wr_valid = 1; wr_addr = 2; wr_data = 8'hA5; rd_addr = 2;
        #1;
        chk("t2_old", 32'(rd_data_o[0]), IV);
        step("t2w");
        idle();
        #1;
        chk("t2_new", 32'(rd_data_o[0]), 8'hA5);
        step("t2r");

        // 3: reinit beats a concurrent write, sweep restores 7 everywhere
        reinit = 1; wr_valid = 1; wr_addr = 1; wr_data = 8'h33;
        step("t3a");
        idle();
        for (int c = 0; c < 4; c++) step("t3s");
        rd_addr = 2;
        #1;
        chk("t3_a2", 32'(rd_data_o[0]), IV);
        read_all("t3_rd");

        // 4: addr3 is out of range for the DEPTH=3 build
        @(negedge clock);
        wr_valid = 1; wr_addr = 3; wr_data = 8'hFF;
        step("t4w");
        idle();
        #1;
        chk("t4_err", 32'(wr_err_o[1]), 1);
        chk("t4_err4", 32'(wr_err_o[0]), 0);
        step("t4");
        reinit = 1;
        step("t4ri");
        idle();
        for (int c = 0; c < 4; c++) step("t4s");
        chk("t4_err_kept", 32'(wr_err_o[1]), 1);
        reset_n = 0;
        step("t4rst");
        chk("t4_err_clr", 32'(wr_err_o[1]), 0);

        // 5: reset during the sweep, then a fresh full sweep
        reset_n = 1;
        step("t5a"); step("t5b");
        reset_n = 0;
        model_reset();
        read_all("t5_rst");
        @(negedge clock);
        step("t5r");
        reset_n = 1;
        for (int c = 0; c < 3; c++) step("t5s");
        chk("t5_notyet", 32'(init_done_o[0]), 0);
        step("t5s4");
        chk("t5_done", 32'(init_done_o[0]), 1);

        // 6: back-to-back writes, last one to the same address wins
        wr_valid = 1;
        wr_addr = 0; wr_data = 1; step("t6a");
        wr_addr = 0; wr_data = 2; step("t6b");
        wr_addr = 1; wr_data = 3; step("t6c");
        idle();
        rd_addr = 0; #1; chk("t6_b0", 32'(rd_data_o[0]), 2);
        rd_addr = 1; #1; chk("t6_b1", 32'(rd_data_o[0]), 3);
        @(negedge clock);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            reset_n  = ($urandom_range(99) != 0);
            reinit   = ($urandom_range(19) == 0);
            wr_valid = ($urandom_range(9) < 7);
            wr_addr  = 2'($urandom_range(3));
            wr_data  = 8'($urandom);
            rd_addr  = 2'($urandom_range(3));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
